// File: rtl/qa_wr_arb_pkg.sv
// Shared types and constants for the CCI channel-1 write arbiter.
package qa_wr_arb_pkg;

   localparam int MDATA_LSB   = 0;
   localparam int MDATA_WIDTH = 13;
   localparam int MAX_CLIENTS = 8;

   // Client id width; a single client still needs one bit of tag.
   function automatic int id_w(input int num_clients);
      return (num_clients <= 2) ? 1 : $clog2(num_clients);
   endfunction

   typedef logic [$clog2(MAX_CLIENTS)-1:0] t_client_id;

endpackage

// File: rtl/qa_wr_arbiter_if.sv
// Client-side write-request bus shared by all requesters of qa_wr_arbiter.
interface qa_wr_arbiter_if #(
   parameter int NUM_CLIENTS = 4,
   parameter int TXHDR_WIDTH = 61,
   parameter int CACHE_WIDTH = 512
);

   logic [NUM_CLIENTS-1:0]             req_valid;
   logic [NUM_CLIENTS*TXHDR_WIDTH-1:0] req_hdr;
   logic [NUM_CLIENTS*CACHE_WIDTH-1:0] req_data;
   logic [NUM_CLIENTS-1:0]             req_grant;

   // Handshake: a client raises req_valid[i] and holds hdr/data stable until
   // req_grant[i] is seen high in the same cycle; that cycle is the only consume.
   modport master (output req_valid, req_hdr, req_data, input req_grant);
   modport slave  (input req_valid, req_hdr, req_data, output req_grant);

endinterface

// File: rtl/qa_rr_arbiter.sv
// Round-robin request-to-one-hot-grant arbiter with a registered priority pointer.
module qa_rr_arbiter
   import qa_wr_arb_pkg::*;
#(
   parameter int NUM_CLIENTS = 4,
   parameter int ID_W        = id_w(NUM_CLIENTS)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic [NUM_CLIENTS-1:0] req,
   output logic [NUM_CLIENTS-1:0] grant,
   output logic [ID_W-1:0]        grant_id,
   output logic                   any_grant
);

   t_client_id ptr;
   t_client_id win;
   logic       found;

   function automatic int wrap(input int v);
      return (v >= NUM_CLIENTS) ? v - NUM_CLIENTS : v;
   endfunction

   // Search starts at the pointer so the last winner has lowest priority.
   always_comb begin
      grant = '0;
      win   = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_CLIENTS; k++) begin
         if (en && !found && req[wrap(int'(ptr) + k)]) begin
            found                        = 1'b1;
            win                          = t_client_id'(wrap(int'(ptr) + k));
            grant[wrap(int'(ptr) + k)]   = 1'b1;
         end
      end
   end

   assign grant_id  = win[ID_W-1:0];
   assign any_grant = found;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (found) begin
         ptr <= (win == t_client_id'(NUM_CLIENTS - 1)) ? '0 : win + t_client_id'(1);
      end
   end

endmodule

// File: rtl/qa_wr_arbiter.sv
// Shares CCI channel-1 writes between NUM_CLIENTS requesters and routes responses back.
// Optional statistics counters are built when QA_WR_ARB_STATS_EN is defined.
module qa_wr_arbiter
   import qa_wr_arb_pkg::*;
#(
   parameter int NUM_CLIENTS     = 4,
   parameter int TXHDR_WIDTH     = 61,
   parameter int RXHDR_WIDTH     = 18,
   parameter int CACHE_WIDTH     = 512,
   parameter int MAX_OUTSTANDING = 64
) (
   input  logic                               vl_clk_LPdomain_32ui,
   input  logic                               ffs_vl_LP32ui_lp2sy_SoftReset_n,
   input  logic                               ffs_vl_LP32ui_lp2sy_InitDnForSys,
   qa_wr_arbiter_if.slave                     clients,
   output logic [TXHDR_WIDTH-1:0]             ffs_vl61_LP32ui_sy2lp_C1TxHdr,
   output logic [CACHE_WIDTH-1:0]             ffs_vl512_LP32ui_sy2lp_C1TxData,
   output logic                               ffs_vl_LP32ui_sy2lp_C1TxWrValid,
   input  logic                               ffs_vl_LP32ui_lp2sy_C1TxAlmFull,
   input  logic [RXHDR_WIDTH-1:0]             ffs_vl18_LP32ui_lp2sy_C0RxHdr,
   input  logic                               ffs_vl_LP32ui_lp2sy_C0RxWrValid,
   input  logic [RXHDR_WIDTH-1:0]             ffs_vl18_LP32ui_lp2sy_C1RxHdr,
   input  logic                               ffs_vl_LP32ui_lp2sy_C1RxWrValid,
   output logic                               done0_valid,
   output logic [id_w(NUM_CLIENTS)-1:0]       done0_id,
   output logic                               done1_valid,
   output logic [id_w(NUM_CLIENTS)-1:0]       done1_id,
   output logic [$clog2(MAX_OUTSTANDING):0]   outstanding
`ifdef QA_WR_ARB_STATS_EN
   ,
   output logic [NUM_CLIENTS*32-1:0]          stat_grants,
   output logic [15:0]                        stat_stalls,
   output logic                               err_underflow
`endif
);

   localparam int ID_W  = id_w(NUM_CLIENTS);
   localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

   logic clk;
   logic rst_n;
   assign clk   = vl_clk_LPdomain_32ui;
   assign rst_n = ffs_vl_LP32ui_lp2sy_SoftReset_n;

`ifndef QA_WR_ARB_STATS_EN
   logic err_underflow;
`endif

   logic                   can_issue;
   logic                   any_grant;
   logic [NUM_CLIENTS-1:0] grant;
   logic [ID_W-1:0]        grant_id;
   logic [TXHDR_WIDTH-1:0] sel_hdr;
   logic [TXHDR_WIDTH-1:0] tx_hdr_next;
   logic [CACHE_WIDTH-1:0] sel_data;

   // Full check uses the registered count, so a same-cycle response cannot free a slot.
   assign can_issue = ffs_vl_LP32ui_lp2sy_InitDnForSys && !ffs_vl_LP32ui_lp2sy_C1TxAlmFull &&
                      (outstanding < CNT_W'(MAX_OUTSTANDING));

   qa_rr_arbiter #(
      .NUM_CLIENTS (NUM_CLIENTS),
      .ID_W        (ID_W)
   ) u_rr (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (can_issue),
      .req       (clients.req_valid),
      .grant     (grant),
      .grant_id  (grant_id),
      .any_grant (any_grant)
   );

   assign clients.req_grant = grant;

   always_comb begin
      sel_hdr  = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         if (grant[i]) begin
            sel_hdr  = clients.req_hdr[i*TXHDR_WIDTH +: TXHDR_WIDTH];
            sel_data = clients.req_data[i*CACHE_WIDTH +: CACHE_WIDTH];
         end
      end
      tx_hdr_next                     = sel_hdr;
      tx_hdr_next[MDATA_LSB +: ID_W]  = grant_id;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ffs_vl_LP32ui_sy2lp_C1TxWrValid <= 1'b0;
         ffs_vl61_LP32ui_sy2lp_C1TxHdr   <= '0;
         ffs_vl512_LP32ui_sy2lp_C1TxData <= '0;
      end else begin
         ffs_vl_LP32ui_sy2lp_C1TxWrValid <= any_grant;
         if (any_grant) begin
            ffs_vl61_LP32ui_sy2lp_C1TxHdr   <= tx_hdr_next;
            ffs_vl512_LP32ui_sy2lp_C1TxData <= sel_data;
         end
      end
   end

   // Only the low ID_W bits of the returned mdata carry the owning client.
   logic unused_rx_bits;
   assign unused_rx_bits = ^{ffs_vl18_LP32ui_lp2sy_C0RxHdr[RXHDR_WIDTH-1:ID_W],
                             ffs_vl18_LP32ui_lp2sy_C1RxHdr[RXHDR_WIDTH-1:ID_W]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done0_valid <= 1'b0;
         done0_id    <= '0;
         done1_valid <= 1'b0;
         done1_id    <= '0;
      end else begin
         done0_valid <= ffs_vl_LP32ui_lp2sy_C0RxWrValid;
         done1_valid <= ffs_vl_LP32ui_lp2sy_C1RxWrValid;
         if (ffs_vl_LP32ui_lp2sy_C0RxWrValid) done0_id <= ffs_vl18_LP32ui_lp2sy_C0RxHdr[ID_W-1:0];
         if (ffs_vl_LP32ui_lp2sy_C1RxWrValid) done1_id <= ffs_vl18_LP32ui_lp2sy_C1RxHdr[ID_W-1:0];
      end
   end

   logic [1:0]     n_rsp;
   logic [CNT_W:0] cnt_up;
   logic [CNT_W:0] cnt_dn;
   logic           underflow;

   assign n_rsp     = {1'b0, ffs_vl_LP32ui_lp2sy_C0RxWrValid} + {1'b0, ffs_vl_LP32ui_lp2sy_C1RxWrValid};
   assign cnt_up    = {1'b0, outstanding} + {{CNT_W{1'b0}}, any_grant};
   assign cnt_dn    = {{(CNT_W-1){1'b0}}, n_rsp};
   assign underflow = cnt_up < cnt_dn;

   // Stray responses (e.g. in flight across a reset) saturate the count at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outstanding   <= '0;
         err_underflow <= 1'b0;
      end else begin
         outstanding <= underflow ? '0 : CNT_W'(cnt_up - cnt_dn);
         if (underflow) err_underflow <= 1'b1;
      end
   end

`ifdef QA_WR_ARB_STATS_EN
   logic [31:0] grant_cnt [NUM_CLIENTS];
   logic [15:0] stall_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CLIENTS; i++) grant_cnt[i] <= '0;
         stall_cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (grant[i]) grant_cnt[i] <= grant_cnt[i] + 32'd1;
         end
         if (|clients.req_valid && ffs_vl_LP32ui_lp2sy_C1TxAlmFull) stall_cnt <= stall_cnt + 16'd1;
      end
   end

   always_comb begin
      stat_grants = '0;
      for (int i = 0; i < NUM_CLIENTS; i++) stat_grants[i*32 +: 32] = grant_cnt[i];
   end

   assign stat_stalls = stall_cnt;
`endif

endmodule

// File: tb/tb_qa_wr_arbiter.sv
// Directed scoreboard bench for qa_wr_arbiter: grants, issue, completions, credit limit, reset.
module tb_qa_wr_arbiter;

   localparam int N    = 4;
   localparam int TXW  = 61;
   localparam int RXW  = 18;
   localparam int CW   = 512;
   localparam int MAXO = 64;
   localparam int IDW  = 2;
   localparam int CNTW = 7;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            init_dn;
   logic            alm_full;
   logic            c0_valid, c1_valid;
   logic [RXW-1:0]  c0_hdr, c1_hdr;
   logic [TXW-1:0]  tx_hdr;
   logic [CW-1:0]   tx_data;
   logic            tx_valid;
   logic            done0_valid, done1_valid;
   logic [IDW-1:0]  done0_id, done1_id;
   logic [CNTW-1:0] outstanding;
`ifdef QA_WR_ARB_STATS_EN
   logic [N*32-1:0] stat_grants;
   logic [15:0]     stat_stalls;
   logic            err_uf_port;
`endif

   int total = 0;
   int bad   = 0;

   logic [TXW-1:0] exp_q[$];
   logic [CW-1:0]  exp_data_q[$];
   logic [IDW-1:0] exp_d0_q[$];
   logic [IDW-1:0] exp_d1_q[$];

   logic [TXW-1:0] cl_hdr  [N];
   logic [CW-1:0]  cl_data [N];
   int             model_outst;
   logic           model_uf;

   qa_wr_arbiter_if #(.NUM_CLIENTS(N), .TXHDR_WIDTH(TXW), .CACHE_WIDTH(CW)) cif ();

   qa_wr_arbiter #(
      .NUM_CLIENTS(N), .TXHDR_WIDTH(TXW), .RXHDR_WIDTH(RXW),
      .CACHE_WIDTH(CW), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .vl_clk_LPdomain_32ui              (clk),
      .ffs_vl_LP32ui_lp2sy_SoftReset_n   (rst_n),
      .ffs_vl_LP32ui_lp2sy_InitDnForSys  (init_dn),
      .clients                           (cif),
      .ffs_vl61_LP32ui_sy2lp_C1TxHdr     (tx_hdr),
      .ffs_vl512_LP32ui_sy2lp_C1TxData   (tx_data),
      .ffs_vl_LP32ui_sy2lp_C1TxWrValid   (tx_valid),
      .ffs_vl_LP32ui_lp2sy_C1TxAlmFull   (alm_full),
      .ffs_vl18_LP32ui_lp2sy_C0RxHdr     (c0_hdr),
      .ffs_vl_LP32ui_lp2sy_C0RxWrValid   (c0_valid),
      .ffs_vl18_LP32ui_lp2sy_C1RxHdr     (c1_hdr),
      .ffs_vl_LP32ui_lp2sy_C1RxWrValid   (c1_valid),
      .done0_valid                       (done0_valid),
      .done0_id                          (done0_id),
      .done1_valid                       (done1_valid),
      .done1_id                          (done1_id),
      .outstanding                       (outstanding)
`ifdef QA_WR_ARB_STATS_EN
      ,
      .stat_grants                       (stat_grants),
      .stat_stalls                       (stat_stalls),
      .err_underflow                     (err_uf_port)
`endif
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (tx_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL tx_unexpected: got hdr %0h expected no write", tx_hdr);
         end else begin
            chk("tx_hdr", tx_hdr, exp_q.pop_front());
            chk("tx_data", tx_data, exp_data_q.pop_front());
         end
      end
      if (done0_valid === 1'b1) begin
         if (exp_d0_q.size() == 0) begin
            total++; bad++;
            $display("FAIL done0_unexpected: got id %0d expected none", done0_id);
         end else chk("done0_id", done0_id, exp_d0_q.pop_front());
      end
      if (done1_valid === 1'b1) begin
         if (exp_d1_q.size() == 0) begin
            total++; bad++;
            $display("FAIL done1_unexpected: got id %0d expected none", done1_id);
         end else chk("done1_id", done1_id, exp_d1_q.pop_front());
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      cif.req_valid = '0;
      alm_full      = 1'b0;
      c0_valid      = 1'b0;
      c1_valid      = 1'b0;
      c0_hdr        = '0;
      c1_hdr        = '0;
   endtask

   task automatic flush_model();
      exp_q.delete();
      exp_data_q.delete();
      exp_d0_q.delete();
      exp_d1_q.delete();
      model_outst = 0;
      model_uf    = 1'b0;
   endtask

   // Called at posedge+1; drives one cycle, checks the grant and registered state
   // at the negedge, queues expected writes/completions and advances the model.
   task automatic cycle(input logic [N-1:0] v, input logic alm,
                        input logic r0, input logic [IDW-1:0] id0,
                        input logic r1, input logic [IDW-1:0] id1,
                        input logic [N-1:0] exp_grant);
      int nxt;
      cif.req_valid = v;
      alm_full      = alm;
      c0_valid      = r0;
      c0_hdr        = {16'h5A5A, id0};
      c1_valid      = r1;
      c1_hdr        = {16'hC3C3, id1};
      @(negedge clk);
      chk("grant", cif.req_grant, exp_grant);
      chk("outstanding", outstanding, model_outst[CNTW-1:0]);
      chk("err_underflow", dut.err_underflow, model_uf);
      for (int i = 0; i < N; i++) begin
         if (exp_grant[i]) begin
            exp_q.push_back({cl_hdr[i][TXW-1:IDW], IDW'(i)});
            exp_data_q.push_back(cl_data[i]);
         end
      end
      if (r0) exp_d0_q.push_back(id0);
      if (r1) exp_d1_q.push_back(id1);
      nxt = model_outst + ((exp_grant != '0) ? 1 : 0) - int'(r0) - int'(r1);
      if (nxt < 0) begin
         nxt      = 0;
         model_uf = 1'b1;
      end
      model_outst = nxt;
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [N-1:0] v, input logic [N-1:0] g);
      cycle(v, 1'b0, 1'b0, '0, 1'b0, '0, g);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_grant"}, cif.req_grant, '0);
      chk({tag, "_wrvalid"}, tx_valid, 1'b0);
      chk({tag, "_txhdr"}, tx_hdr, '0);
      chk({tag, "_txdata"}, tx_data, '0);
      chk({tag, "_done0"}, {done0_valid, done0_id}, '0);
      chk({tag, "_done1"}, {done1_valid, done1_id}, '0);
      chk({tag, "_outstanding"}, outstanding, '0);
      chk({tag, "_err_underflow"}, dut.err_underflow, 1'b0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [TXW-1:0] base;
      base = 61'h0234_5678_9ABC_0000;
      for (int i = 0; i < N; i++) begin
         cl_hdr[i]  = base | (TXW'(i) << 20) | TXW'(13'h1FFC);
         cl_data[i] = {16{32'hD000_0000 + 32'(i)}};
         cif.req_hdr[i*TXW +: TXW] = cl_hdr[i];
         cif.req_data[i*CW +: CW]  = cl_data[i];
      end
      rst_n   = 1'b0;
      init_dn = 1'b0;
      idle_inputs();
      flush_model();
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single client 2, mdata 0x1FFC; nothing issues until the system is ready.
      req(4'b0100, 4'b0000);
      init_dn = 1'b1;
      req(4'b0100, 4'b0100);
      cycle(4'b0000, 1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 4'b0000);
      req(4'b0000, 4'b0000);

      // Fresh reset so the pointer starts at 0, then all clients valid to the credit limit.
      rst_n = 1'b0;
      flush_model();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < MAXO; k++) req(4'b1111, N'(1) << (k % N));
      repeat (3) req(4'b1111, 4'b0000);
      // A response at the limit frees a slot only from the following cycle.
      cycle(4'b1111, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 4'b0000);
      req(4'b1111, 4'b0001);
      for (int k = 0; k < MAXO / 2; k++)
         cycle(4'b0000, 1'b0, 1'b1, IDW'(k % N), 1'b1, IDW'((k + 1) % N), 4'b0000);

      // AlmFull stalls client 1, then releases it the same cycle it drops.
      for (int k = 0; k < 10; k++) cycle(4'b0010, 1'b1, 1'b0, '0, 1'b0, '0, 4'b0000);
      cycle(4'b0010, 1'b0, 1'b0, '0, 1'b0, '0, 4'b0010);
      // AlmFull rising right after a grant: the registered write still issues.
      cycle(4'b1000, 1'b1, 1'b0, '0, 1'b0, '0, 4'b0000);
      req(4'b1000, 4'b1000);
      req(4'b0001, 4'b0001);
      req(4'b0100, 4'b0100);
      req(4'b0010, 4'b0010);
      // Grant plus two responses for client 3 at outstanding = 5.
      cycle(4'b1111, 1'b0, 1'b1, 2'd3, 1'b1, 2'd3, 4'b0100);
      req(4'b0000, 4'b0000);
      cycle(4'b0000, 1'b0, 1'b1, 2'd0, 1'b1, 2'd1, 4'b0000);
      cycle(4'b0000, 1'b0, 1'b1, 2'd2, 1'b1, 2'd3, 4'b0000);
      // Stray response at zero.
      cycle(4'b0000, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 4'b0000);
      req(4'b0000, 4'b0000);

      // Build 20 in flight with the pointer at 3, then reset mid-operation.
      for (int k = 0; k < 20; k++) req(4'b1111, N'(1) << ((k + 3) % N));
      chk("pre_reset_wrvalid", tx_valid, 1'b1);
      chk("pre_reset_outstanding", outstanding, CNTW'(20));
      #1;
      rst_n = 1'b0;
      idle_inputs();
      #1;
      chk_all_zero("async_reset");
      flush_model();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      // Late response after reset, then pointer restarts at client 0.
      cycle(4'b0000, 1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 4'b0000);
      req(4'b1111, 4'b0001);
      req(4'b1111, 4'b0010);
      cycle(4'b0000, 1'b0, 1'b1, 2'd0, 1'b1, 2'd1, 4'b0000);
      req(4'b0000, 4'b0000);
      req(4'b0000, 4'b0000);

      chk("tx_queue_drained", exp_q.size(), 0);
      chk("done0_queue_drained", exp_d0_q.size(), 0);
      chk("done1_queue_drained", exp_d1_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
